alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares the single core ALU between two requesters (port 0: pipeline execute stage, port 1: auxiliary multi-cycle unit) using valid/ready handshakes.
- Arbitrates round-robin.
- Registers the winning op and operands onto the ALU inputs.
- Waits a configurable ALU latency, captures the result, and returns it on the winner's response channel.
- Sits between the requesters and the ALU's ALUop/operand_A/operand_B/result interface.

Parameters:
ALU_LAT, 1, cycles from the ALU inputs becoming stable to result_i being sampled; legal range 1..15.
OPW, 6, ALU opcode width.
DW, 32, operand/result width.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
req0_valid_i  in  1  requester 0 has an op
req0_ready_o  out  1  requester 0 op accepted this cycle (when valid)
req0_aluop_i  in  OPW  requester 0 opcode
req0_opa_i  in  DW  requester 0 operand A
req0_opb_i  in  DW  requester 0 operand B
req1_valid_i / req1_ready_o / req1_aluop_i / req1_opa_i / req1_opb_i  as above for requester 1
resp0_valid_o  out  1  result for requester 0 available
resp0_ready_i  in  1  requester 0 takes result
resp1_valid_o / resp1_ready_i  as above for requester 1
resp_result_o  out  DW  result, shared by both response channels
ALUop_o  out  OPW  to ALU opcode
operand_A_o  out  DW  to ALU operand A
operand_B_o  out  DW  to ALU operand B
result_i  in  DW  from ALU, combinational from ALU inputs
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_i high at a clock edge):
  - state=IDLE, rr_q=0 (requester 0 preferred).
  - All ready/valid outputs 0; ALUop_o, operand_A_o, operand_B_o, resp_result_o = 0; latency counter 0.
- Reset mid-operation aborts the transaction. No response is issued for it.
- States: IDLE, EXEC, RESP.
- IDLE:
  - grant = the only valid requester. If both are valid, the requester rr_q points at.
  - reqN_ready_o = 1 combinationally only for the granted N, and only in IDLE. The other ready stays 0.
  - On a valid&ready handshake: latch aluop/opa/opb into the ALU output registers, remember the owner, set cnt=ALU_LAT-1, go to EXEC.
  - No valid input: stay in IDLE, all readys 0.
- EXEC:
  - ALU outputs are held stable.
  - If cnt==0: capture result_i into resp_result_o and go to RESP. Otherwise decrement cnt.
  - With ALU_LAT=1, EXEC lasts exactly 1 cycle.
- RESP:
  - respN_valid_o=1 for the owner only. resp_result_o is held.
  - On respN_valid_o & respN_ready_i: clear valid, set rr_q to the non-owner (last served gets lowest priority), go to IDLE.
  - Valid stays high indefinitely until ready arrives.
- Latency/throughput:
  - Accept at cycle t, result captured at the end of cycle t+ALU_LAT, resp valid at t+ALU_LAT+1.
  - Back-to-back peak rate is one op per ALU_LAT+2 cycles when resp ready is held high.
- ALU outputs keep the last issued values in IDLE/RESP; they are not cleared.
- Opcodes are passed through unchanged, with no decoding. Undefined opcodes are not checked.
- Requester inputs are ignored outside IDLE.
- A requester may drop valid before ready is given with no effect.
- Requests arriving during EXEC/RESP are arbitrated on return to IDLE.
- resp_ready_i asserted before resp valid has no effect.
- A single requester valid continuously is served every turn. rr_q only biases ties.

Test Plan:
Bench ALU model: result_i = A+B when op=6'b000000, A-B when op=6'b000001. Default ALU_LAT=1.
1. Reset then req0 {op 000000, A=200, B=14}, resp0_ready_i=1 -> req0_ready_o pulses the same cycle; resp0_valid_o rises 2 cycles later with resp_result_o=214; resp1_valid_o stays 0.
2. req0 and req1 both valid from reset: req0 {000000,200,14}, req1 {000001,200,14} -> req0 served first (214), then req1 gets ready in the next IDLE, result 186; then both re-asserted -> req0 wins again (rr_q back to 0).
3. resp0_ready_i held 0 for 5 cycles after resp0_valid_o -> valid and result 214 held stable, req1_ready_o stays 0, busy_o=1; release -> IDLE next cycle.
4. ALU_LAT=3, req1 {000001,200,14} -> ALU outputs stable for 3 EXEC cycles; resp1_valid_o asserted 4 cycles after accept with 186.
5. rst_i asserted during EXEC -> next cycle state IDLE, no resp valid ever seen for the aborted op, ALU outputs 0, rr_q=0.
6. Continuous req1 valid with req0 idle, 3 ops -> each accepted every 3 cycles (ALU_LAT=1, resp ready high), responses in order.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters; result returned ALU_LAT+1 cycles after accept.
// Backpressure: one op in flight; requesters stall outside IDLE, the response is held until its ready arrives.
module alu_share_arbiter #(
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned OPW     = 6,
   parameter int unsigned DW      = 32
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           req0_valid_i,
   output logic           req0_ready_o,
   input  logic [OPW-1:0] req0_aluop_i,
   input  logic [DW-1:0]  req0_opa_i,
   input  logic [DW-1:0]  req0_opb_i,
   input  logic           req1_valid_i,
   output logic           req1_ready_o,
   input  logic [OPW-1:0] req1_aluop_i,
   input  logic [DW-1:0]  req1_opa_i,
   input  logic [DW-1:0]  req1_opb_i,
   output logic           resp0_valid_o,
   input  logic           resp0_ready_i,
   output logic           resp1_valid_o,
   input  logic           resp1_ready_i,
   output logic [DW-1:0]  resp_result_o,
   output logic [OPW-1:0] ALUop_o,
   output logic [DW-1:0]  operand_A_o,
   output logic [DW-1:0]  operand_B_o,
   input  logic [DW-1:0]  result_i,
   output logic           busy_o
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e         state_q, state_d;
   logic           rr_q, rr_d;
   logic           owner_q, owner_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [OPW-1:0] aluop_q, aluop_d;
   logic [DW-1:0]  opa_q, opa_d;
   logic [DW-1:0]  opb_q, opb_d;
   logic [DW-1:0]  result_q, result_d;
   logic           resp0_valid_q, resp0_valid_d;
   logic           resp1_valid_q, resp1_valid_d;
   logic           grant1;

   always_comb begin
      state_d       = state_q;
      rr_d          = rr_q;
      owner_d       = owner_q;
      cnt_d         = cnt_q;
      aluop_d       = aluop_q;
      opa_d         = opa_q;
      opb_d         = opb_q;
      result_d      = result_q;
      resp0_valid_d = resp0_valid_q;
      resp1_valid_d = resp1_valid_q;
      req0_ready_o  = 1'b0;
      req1_ready_o  = 1'b0;
      // rr_q only breaks ties; a lone valid requester always wins
      grant1        = req1_valid_i & (~req0_valid_i | rr_q);

      case (state_q)
         IDLE: begin
            if (req0_valid_i | req1_valid_i) begin
               req0_ready_o = ~grant1;
               req1_ready_o = grant1;
               owner_d      = grant1;
               aluop_d      = grant1 ? req1_aluop_i : req0_aluop_i;
               opa_d        = grant1 ? req1_opa_i   : req0_opa_i;
               opb_d        = grant1 ? req1_opb_i   : req0_opb_i;
               cnt_d        = 4'(ALU_LAT - 1);
               state_d      = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               result_d      = result_i;
               resp0_valid_d = ~owner_q;
               resp1_valid_d = owner_q;
               state_d       = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if ((resp0_valid_q & resp0_ready_i) | (resp1_valid_q & resp1_ready_i)) begin
               resp0_valid_d = 1'b0;
               resp1_valid_d = 1'b0;
               rr_d          = ~owner_q;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         rr_q          <= 1'b0;
         owner_q       <= 1'b0;
         cnt_q         <= 4'd0;
         aluop_q       <= '0;
         opa_q         <= '0;
         opb_q         <= '0;
         result_q      <= '0;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_q          <= rr_d;
         owner_q       <= owner_d;
         cnt_q         <= cnt_d;
         aluop_q       <= aluop_d;
         opa_q         <= opa_d;
         opb_q         <= opb_d;
         result_q      <= result_d;
         resp0_valid_q <= resp0_valid_d;
         resp1_valid_q <= resp1_valid_d;
      end
   end

   assign ALUop_o       = aluop_q;
   assign operand_A_o   = opa_q;
   assign operand_B_o   = opb_q;
   assign resp_result_o = result_q;
   assign resp0_valid_o = resp0_valid_q;
   assign resp1_valid_o = resp1_valid_q;
   assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: two arbiter instances (ALU_LAT=1 and ALU_LAT=3) share stimulus, each with its own ALU model.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0v, r1v, p0r, p1r;
   logic [5:0]  r0op, r1op;
   logic [31:0] r0a, r0b, r1a, r1b;

   logic        d1_rdy0, d1_rdy1, d1_rv0, d1_rv1, d1_busy;
   logic [31:0] d1_res, d1_a, d1_b, d1_alu;
   logic [5:0]  d1_op;
   logic        d3_rdy0, d3_rdy1, d3_rv0, d3_rv1, d3_busy;
   logic [31:0] d3_res, d3_a, d3_b, d3_alu;
   logic [5:0]  d3_op;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   always_comb d1_alu = (d1_op == 6'd0) ? d1_a + d1_b : (d1_op == 6'd1) ? d1_a - d1_b : 32'd0;
   always_comb d3_alu = (d3_op == 6'd0) ? d3_a + d3_b : (d3_op == 6'd1) ? d3_a - d3_b : 32'd0;

   alu_share_arbiter #(.ALU_LAT(1)) dut1 (
      .clk_i(clk), .rst_i(rst),
      .req0_valid_i(r0v), .req0_ready_o(d1_rdy0), .req0_aluop_i(r0op), .req0_opa_i(r0a), .req0_opb_i(r0b),
      .req1_valid_i(r1v), .req1_ready_o(d1_rdy1), .req1_aluop_i(r1op), .req1_opa_i(r1a), .req1_opb_i(r1b),
      .resp0_valid_o(d1_rv0), .resp0_ready_i(p0r), .resp1_valid_o(d1_rv1), .resp1_ready_i(p1r),
      .resp_result_o(d1_res), .ALUop_o(d1_op), .operand_A_o(d1_a), .operand_B_o(d1_b),
      .result_i(d1_alu), .busy_o(d1_busy));

   alu_share_arbiter #(.ALU_LAT(3)) dut3 (
      .clk_i(clk), .rst_i(rst),
      .req0_valid_i(r0v), .req0_ready_o(d3_rdy0), .req0_aluop_i(r0op), .req0_opa_i(r0a), .req0_opb_i(r0b),
      .req1_valid_i(r1v), .req1_ready_o(d3_rdy1), .req1_aluop_i(r1op), .req1_opa_i(r1a), .req1_opb_i(r1b),
      .resp0_valid_o(d3_rv0), .resp0_ready_i(p0r), .resp1_valid_o(d3_rv1), .resp1_ready_i(p1r),
      .resp_result_o(d3_res), .ALUop_o(d3_op), .operand_A_o(d3_a), .operand_B_o(d3_b),
      .result_i(d3_alu), .busy_o(d3_busy));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   logic [5:0]  t6_op  [3] = '{6'd1, 6'd0, 6'd1};
   logic [31:0] t6_a   [3] = '{32'd100, 32'd110, 32'd120};
   logic [31:0] t6_b   [3] = '{32'd1, 32'd2, 32'd3};
   logic [31:0] t6_exp [3] = '{32'd99, 32'd112, 32'd117};

   initial begin
      rst = 1'b1; r0v = 1'b0; r1v = 1'b0; p0r = 1'b0; p1r = 1'b0;
      r0op = '0; r1op = '0; r0a = '0; r0b = '0; r1a = '0; r1b = '0;

      // 1: reset state, then single req0 add
      do_reset();
      #1;
      chk1("rst_busy", d1_busy, 1'b0);
      chk1("rst_rdy0", d1_rdy0, 1'b0);
      chk1("rst_rv0", d1_rv0, 1'b0);
      chkw("rst_aluop", 32'(d1_op), 32'd0);
      chkw("rst_opa", d1_a, 32'd0);
      chkw("rst_res", d1_res, 32'd0);
      r0v = 1'b1; r0op = 6'd0; r0a = 32'd200; r0b = 32'd14; p0r = 1'b1;
      #1;
      chk1("t1_rdy0", d1_rdy0, 1'b1);
      chk1("t1_rdy1", d1_rdy1, 1'b0);
      tick();
      r0v = 1'b0;
      #1;
      chk1("t1_exec_busy", d1_busy, 1'b1);
      chkw("t1_exec_opa", d1_a, 32'd200);
      chkw("t1_exec_opb", d1_b, 32'd14);
      chk1("t1_exec_rv0", d1_rv0, 1'b0);
      tick();
      chk1("t1_rv0", d1_rv0, 1'b1);
      chkw("t1_res", d1_res, 32'd214);
      chk1("t1_rv1", d1_rv1, 1'b0);
      tick();
      chk1("t1_done_rv0", d1_rv0, 1'b0);
      chk1("t1_done_busy", d1_busy, 1'b0);

      // 2: both valid from reset, round-robin alternation
      do_reset();
      r0v = 1'b1; r0op = 6'd0; r0a = 32'd200; r0b = 32'd14;
      r1v = 1'b1; r1op = 6'd1; r1a = 32'd200; r1b = 32'd14;
      p0r = 1'b1; p1r = 1'b1;
      #1;
      chk1("t2_rdy0", d1_rdy0, 1'b1);
      chk1("t2_rdy1", d1_rdy1, 1'b0);
      tick();
      r0v = 1'b0;
      tick();
      chk1("t2_rv0", d1_rv0, 1'b1);
      chkw("t2_res0", d1_res, 32'd214);
      chk1("t2_resp_rdy1", d1_rdy1, 1'b0);
      tick();
      r0v = 1'b1;
      #1;
      chk1("t2_rr_rdy1", d1_rdy1, 1'b1);
      chk1("t2_rr_rdy0", d1_rdy0, 1'b0);
      tick();
      tick();
      chk1("t2_rv1", d1_rv1, 1'b1);
      chkw("t2_res1", d1_res, 32'd186);
      chk1("t2_rv0_low", d1_rv0, 1'b0);
      tick();
      chk1("t2_again_rdy0", d1_rdy0, 1'b1);
      chk1("t2_again_rdy1", d1_rdy1, 1'b0);

      // 3: hold resp0 ready low for 5 cycles
      tick();
      r0v = 1'b0; p0r = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk1("t3_rv0", d1_rv0, 1'b1);
         chkw("t3_res", d1_res, 32'd214);
         chk1("t3_rdy1", d1_rdy1, 1'b0);
         chk1("t3_busy", d1_busy, 1'b1);
         tick();
      end
      p0r = 1'b1;
      tick();
      chk1("t3_rel_rv0", d1_rv0, 1'b0);
      chk1("t3_rel_busy", d1_busy, 1'b0);
      chk1("t3_rel_rdy1", d1_rdy1, 1'b1);
      r1v = 1'b0;

      // 4: ALU_LAT=3 instance, req1 subtract
      do_reset();
      r1v = 1'b1; r1op = 6'd1; r1a = 32'd200; r1b = 32'd14; p1r = 1'b1;
      #1;
      chk1("t4_rdy1", d3_rdy1, 1'b1);
      tick();
      r1v = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chkw("t4_opa", d3_a, 32'd200);
         chkw("t4_opb", d3_b, 32'd14);
         chkw("t4_aluop", 32'(d3_op), 32'd1);
         chk1("t4_rv1_low", d3_rv1, 1'b0);
         chk1("t4_busy", d3_busy, 1'b1);
         tick();
      end
      chk1("t4_rv1", d3_rv1, 1'b1);
      chkw("t4_res", d3_res, 32'd186);
      chk1("t4_rv0", d3_rv0, 1'b0);
      tick();
      chk1("t4_done_busy", d3_busy, 1'b0);

      // 5: reset during EXEC aborts the op and clears rr_q
      do_reset();
      r0v = 1'b1; r0op = 6'd0; r0a = 32'd5; r0b = 32'd7; p0r = 1'b1;
      tick();
      r0v = 1'b0;
      tick();
      chkw("t5_pre_res", d1_res, 32'd12);
      tick();
      r1v = 1'b1; r1op = 6'd1; r1a = 32'd200; r1b = 32'd14;
      tick();
      r1v = 1'b0;
      chk1("t5_exec_busy", d1_busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("t5_busy", d1_busy, 1'b0);
      chkw("t5_opa", d1_a, 32'd0);
      chkw("t5_opb", d1_b, 32'd0);
      chkw("t5_aluop", 32'(d1_op), 32'd0);
      chkw("t5_res", d1_res, 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk1("t5_no_rv1", d1_rv1, 1'b0);
         chk1("t5_no_rv0", d1_rv0, 1'b0);
         tick();
      end
      r0v = 1'b1; r1v = 1'b1;
      #1;
      chk1("t5_rr_rdy0", d1_rdy0, 1'b1);
      chk1("t5_rr_rdy1", d1_rdy1, 1'b0);
      r0v = 1'b0; r1v = 1'b0;

      // 6: continuous req1, one op every 3 cycles, responses in order
      do_reset();
      p1r = 1'b1; r1v = 1'b1;
      for (int k = 0; k < 3; k++) begin
         r1op = t6_op[k]; r1a = t6_a[k]; r1b = t6_b[k];
         #1;
         chk1("t6_rdy1", d1_rdy1, 1'b1);
         tick();
         chk1("t6_exec_rdy1", d1_rdy1, 1'b0);
         tick();
         chk1("t6_rv1", d1_rv1, 1'b1);
         chkw("t6_res", d1_res, t6_exp[k]);
         chk1("t6_resp_rdy1", d1_rdy1, 1'b0);
         tick();
      end
      r1v = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
